demorgan_sweep_checker: RTL and testbench
=========================================

Name: demorgan_sweep_checker

Overview:
Exhaustive stimulus-and-check stage wrapped around the three-input De Morgan logic block `d = ~((a & b) | c)`.
- Upstream role: drives all 8 combinations of {a,b,c} into the logic under test.
- Downstream role: samples the returned `d` and compares it against the equivalent De Morgan form `(~a | ~b) & ~c`.
- Reports pass/fail, mismatch count and first failing vector, for board-level self-test of the week-5 logic.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before `d` is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; accepted only in IDLE or DONE.
- a  output  1  stimulus bit 2 (vector MSB) to the logic under test.
- b  output  1  stimulus bit 1 to the logic under test.
- c  output  1  stimulus bit 0 (vector LSB) to the logic under test.
- d  input  1  response from the logic under test.
- busy  output  1  high while a sweep is running.
- done  output  1  high in DONE; sticky until the next accepted start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  4  number of mismatching vectors in the last sweep, 0..8.
- fail_pulse  output  1  one-cycle pulse at each mismatching sample edge.
- first_fail_vec  output  3  {a,b,c} of the first mismatch in the sweep.
- first_fail_valid  output  1  set on the first mismatch of a sweep.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, vector counter=0, settle counter=0, and all outputs 0 (a, b, c, busy, done, pass, err_count, fail_pulse, first_fail_vec, first_fail_valid).
- All outputs are registered. Expected value: `exp = (~a | ~b) & ~c`, computed from the registered a, b, c.
- States: IDLE, RUN, DONE.
- IDLE:
  - a/b/c held at 0.
  - start=1 at an edge (E0) -> RUN. At that edge: {a,b,c}=3'b000, settle counter=0, busy=1.
  - err_count, first_fail_valid, first_fail_vec and pass are cleared at the same edge.
- RUN:
  - Vector k is presented from edge E_k = E0 + k*SETTLE_CYCLES.
  - The settle counter increments each edge.
  - At edge E_k + SETTLE_CYCLES, `d` (its pre-edge value) is compared with `exp`.
  - On mismatch at that edge: err_count+1; fail_pulse=1 for one cycle; if first_fail_valid=0, first_fail_vec={a,b,c} and first_fail_valid=1.
  - At the same edge, if k<7: the vector increments (a/b/c change), the settle counter returns to 0, and the state stays RUN.
  - If k==7: state -> DONE, busy=0, done=1, pass=(final err_count==0). Final err_count includes the mismatch at this edge.
  - Timing: done rises exactly 8*SETTLE_CYCLES edges after E0.
- DONE:
  - a/b/c hold vector 3'b111.
  - Results are held.
  - start=1 -> same action as start in IDLE (restart): done=0, results cleared, vector 000.
- Start handling: start is ignored while in RUN. It is level-sampled, so holding start high in DONE restarts back-to-back.
- Reset mid-sweep: immediate return to reset values; partial results are discarded.
- err_count maximum is 8; no saturation logic is needed (4 bits).
- The `d` input is sampled directly. The logic under test is combinational and on the same clock domain, so no synchronizer is required.

Test Plan:
1. SETTLE_CYCLES=2, `d` driven by the correct function, start pulse -> vectors 000..111 each held 2 cycles; done=1 at E0+16; pass=1, err_count=0, first_fail_valid=0, no fail_pulse.
2. `d` stuck at 0 -> mismatches at 000, 010, 100 -> err_count=3, first_fail_vec=3'b000, pass=0, three fail_pulses.
3. `d` driven as the inverted function -> err_count=8, first_fail_vec=000, pass=0, fail_pulse high on all 8 sample edges.
4. rst asserted at E0+7 during RUN -> all outputs 0 immediately (asynchronous); a following start runs a clean sweep with pass=1.
5. start re-pulsed at E0+5 while busy -> ignored; done still at E0+16 with correct results. Then start in DONE -> done drops, err_count clears to 0, and a new sweep completes.
6. SETTLE_CYCLES=1, `d` stuck at 1 -> mismatches at the 5 vectors 001, 011, 101, 110, 111 -> err_count=5, first_fail_vec=3'b001, done at E0+8.

Source files
------------

// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: drives all 8 {a,b,c} vectors into ~((a&b)|c) and
// checks each returned d against the De Morgan form (~a|~b)&~c.
module demorgan_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_pulse,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state;
    logic [7:0] settle;
    logic       exp_d;
    logic       sample;
    logic       mism;
    logic [3:0] err_next;
    assign exp_d    = (~a | ~b) & ~c;
    assign sample   = settle == 8'(SETTLE_CYCLES - 1);
    assign mism     = sample && (d != exp_d);
    assign err_next = err_count + {3'b000, mism};
    // {a,b,c} doubles as the vector counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            settle           <= 8'd0;
            {a, b, c}        <= 3'b000;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 4'd0;
            fail_pulse       <= 1'b0;
            first_fail_vec   <= 3'b000;
            first_fail_valid <= 1'b0;
        end else begin
            fail_pulse <= 1'b0;
            if (state != RUN && start) begin
                state            <= RUN;
                settle           <= 8'd0;
                {a, b, c}        <= 3'b000;
                busy             <= 1'b1;
                done             <= 1'b0;
                pass             <= 1'b0;
                err_count        <= 4'd0;
                first_fail_vec   <= 3'b000;
                first_fail_valid <= 1'b0;
            end else if (state == RUN) begin
                settle <= settle + 8'd1;
                if (sample) begin
                    settle     <= 8'd0;
                    err_count  <= err_next;
                    fail_pulse <= mism;
                    if (mism && !first_fail_valid) begin
                        first_fail_vec   <= {a, b, c};
                        first_fail_valid <= 1'b1;
                    end
                    if ({a, b, c} == 3'b111) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_next == 4'd0;
                    end else begin
                        {a, b, c} <= {a, b, c} + 3'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// tb_demorgan_sweep_checker: directed sweeps with a scoreboard of expected
// sweep results popped by a monitor on each rising done.
module tb_demorgan_sweep_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start0 = 1'b0, start1 = 1'b0;
    logic a0, b0, c0, d0, busy0, done0, pass0, fp0, ffval0;
    logic a1, b1, c1, d1, busy1, done1, pass1, fp1, ffval1;
    logic [3:0] err0, err1;
    logic [2:0] ffv0, ffv1;
    int mode0 = 0, mode1 = 3;

    demorgan_sweep_checker #(.SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_pulse(fp0),
        .first_fail_vec(ffv0), .first_fail_valid(ffval0));
    demorgan_sweep_checker #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_pulse(fp1),
        .first_fail_vec(ffv1), .first_fail_valid(ffval1));

    // 0: correct logic, 1: stuck at 0, 2: inverted, 3: stuck at 1
    function automatic logic lut(input int m, input logic x, input logic y, input logic z);
        return m == 0 ? ~((x & y) | z) : m == 1 ? 1'b0 : m == 2 ? ((x & y) | z) : 1'b1;
    endfunction
    assign d0 = lut(mode0, a0, b0, c0);
    assign d1 = lut(mode1, a1, b1, c1);

    typedef struct {
        int err;
        int ffv;
        int ffval;
        int pass;
        int pulses;
    } exp_t;
    exp_t q0[$], q1[$];
    int checks = 0, failures = 0;

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", n, act, req);
        end
    endtask

    logic busy0_q = 1'b0, done0_q = 1'b0, busy1_q = 1'b0, done1_q = 1'b0;
    int cnt0 = 0, pl0 = 0, cnt1 = 0, pl1 = 0;
    exp_t e0, e1;

    always @(negedge clk) begin
        if (busy0 && !busy0_q) begin cnt0 = 0; pl0 = 0; end else cnt0++;
        if (fp0) pl0++;
        if (done0 && !done0_q) begin
            if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("u0_err_count", int'(err0), e0.err);
                chk("u0_first_fail_vec", int'(ffv0), e0.ffv);
                chk("u0_first_fail_valid", int'(ffval0), e0.ffval);
                chk("u0_pass", int'(pass0), e0.pass);
                chk("u0_fail_pulses", pl0, e0.pulses);
                chk("u0_done_latency", cnt0, 16);
            end
        end
        busy0_q = busy0;
        done0_q = done0;
    end

    always @(negedge clk) begin
        if (busy1 && !busy1_q) begin cnt1 = 0; pl1 = 0; end else cnt1++;
        if (fp1) pl1++;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("u1_err_count", int'(err1), e1.err);
                chk("u1_first_fail_vec", int'(ffv1), e1.ffv);
                chk("u1_first_fail_valid", int'(ffval1), e1.ffval);
                chk("u1_pass", int'(pass1), e1.pass);
                chk("u1_fail_pulses", pl1, e1.pulses);
                chk("u1_done_latency", cnt1, 8);
            end
        end
        busy1_q = busy1;
        done1_q = done1;
    end

    task automatic sweep(input bit inst, input bit push, input exp_t e);
        @(negedge clk);
        if (push) begin
            if (inst) q1.push_back(e);
            else q0.push_back(e);
        end
        if (inst) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit inst);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = inst ? done1 : done0;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    function automatic int outs0();
        return int'({a0, b0, c0, busy0, done0, pass0, err0, fp0, ffv0, ffval0});
    endfunction
    function automatic int outs1();
        return int'({a1, b1, c1, busy1, done1, pass1, err1, fp1, ffv1, ffval1});
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("u0_reset_outputs", outs0(), 0);
        chk("u1_reset_outputs", outs1(), 0);
        rst = 1'b0;
        mode0 = 0;
        sweep(0, 1, '{0, 0, 0, 1, 0});
        chk("u0_busy_after_start", int'(busy0), 1);
        wait_done(0);
        mode0 = 1;
        sweep(0, 1, '{3, 0, 1, 0, 3});
        wait_done(0);
        mode0 = 2;
        sweep(0, 1, '{8, 0, 1, 0, 8});
        wait_done(0);
        mode0 = 0;
        sweep(0, 0, '{0, 0, 0, 0, 0});
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("u0_async_reset_outputs", outs0(), 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 1, '{0, 0, 0, 1, 0});
        wait_done(0);
        mode0 = 1;
        sweep(0, 1, '{3, 0, 1, 0, 3});
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0);
        mode0 = 0;
        sweep(0, 1, '{0, 0, 0, 1, 0});
        chk("u0_restart_done_low", int'(done0), 0);
        chk("u0_restart_err_cleared", int'(err0), 0);
        chk("u0_restart_vector", int'({a0, b0, c0}), 0);
        wait_done(0);
        sweep(1, 1, '{5, 1, 1, 0, 5});
        wait_done(1);
        repeat (2) @(negedge clk);
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
